// File: rtl/mmu_mem_responder_pkg.sv
// Shared definitions for the memory-side responder: default widths,
// the request FSM state encoding and the process-0 reset window.
package cpu_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_VADDR_W = 16;
    localparam int DEF_PADDR_W = 10;
    localparam int DEF_PROC_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XLATE  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Process 0 owns the whole RAM out of reset (2**PADDR_W words).
    localparam logic [DEF_PADDR_W:0] LIMIT_ALL = {1'b1, {DEF_PADDR_W{1'b0}}};

endpackage

// File: rtl/mmu_mem_responder_ram.sv
// Single-port, single-clock RAM with registered read data.
module ram_sp_1clk #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Read-first port: dout holds its value whenever en is low.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= din;
            end
            dout <= mem_r[addr];
        end
    end

endmodule

// File: rtl/mmu_mem_responder.sv
// Memory-side responder: base/limit translation per process, bounds fault,
// one access to a private RAM and exactly one response per accepted request.
module mmu_mem_responder
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VADDR_W = DEF_VADDR_W,
    parameter int PADDR_W = DEF_PADDR_W,
    parameter int PROC_W  = DEF_PROC_W
) (
    input  logic               clka,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [PROC_W-1:0]  req_proc,
    input  logic [VADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_fault,
    input  logic               cfg_we,
    input  logic [PROC_W-1:0]  cfg_proc,
    input  logic [PADDR_W-1:0] cfg_base,
    input  logic [PADDR_W:0]   cfg_limit
);

    localparam int NPROC = 2**PROC_W;
    localparam logic [VADDR_W:0] RAM_TOP = {{(VADDR_W+1-PADDR_W){1'b0}}, {PADDR_W{1'b1}}};

    state_e               state_r, state_nxt_s;
    logic                 wr_r;
    logic [PROC_W-1:0]    proc_r;
    logic [VADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]    wdata_r;
    logic [PADDR_W-1:0]   paddr_r;
    logic [PADDR_W-1:0]   base_r  [NPROC];
    logic [PADDR_W:0]     limit_r [NPROC];
    logic                 req_ready_r, rsp_valid_r, rsp_fault_r, rsp_from_ram_r;
    logic                 fault_s, ram_en_s;
    logic [VADDR_W:0]     addr_ext_s, limit_ext_s, sum_s;
    logic [PADDR_W-1:0]   paddr_s;
    logic [DATA_W-1:0]    ram_dout_s;

    // Bounds check at VADDR_W+1 bits so base+addr can never wrap.
    always_comb begin
        addr_ext_s  = {1'b0, addr_r};
        limit_ext_s = {{(VADDR_W-PADDR_W){1'b0}}, limit_r[proc_r]};
        sum_s       = {{(VADDR_W+1-PADDR_W){1'b0}}, base_r[proc_r]} + addr_ext_s;
        fault_s     = (addr_ext_s >= limit_ext_s) || (sum_s > RAM_TOP);
        paddr_s     = base_r[proc_r] + addr_r[PADDR_W-1:0];
    end

    // Next-state decode and RAM enable.
    always_comb begin
        state_nxt_s = state_r;
        ram_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = XLATE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XLATE: begin
                if (fault_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            ACCESS: begin
                ram_en_s    = 1'b1;
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, request capture and registered handshake/response flags.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            req_ready_r    <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_fault_r    <= 1'b0;
            rsp_from_ram_r <= 1'b0;
            wr_r           <= 1'b0;
            proc_r         <= {PROC_W{1'b0}};
            addr_r         <= {VADDR_W{1'b0}};
            wdata_r        <= {DATA_W{1'b0}};
            paddr_r        <= {PADDR_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        wr_r    <= req_write;
                        proc_r  <= req_proc;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                    end
                end
                XLATE: begin
                    paddr_r        <= paddr_s;
                    rsp_fault_r    <= fault_s;
                    rsp_from_ram_r <= 1'b0;
                end
                ACCESS: rsp_from_ram_r <= ~wr_r;
                RESP: begin
                    if (rsp_ready) begin
                        rsp_fault_r    <= 1'b0;
                        rsp_from_ram_r <= 1'b0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Per-process base/limit pairs; process 0 spans all of RAM after reset.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPROC; i++) begin
                base_r[i]  <= {PADDR_W{1'b0}};
                limit_r[i] <= (i == 0) ? LIMIT_ALL : {(PADDR_W+1){1'b0}};
            end
        end else if (cfg_we) begin
            base_r[cfg_proc]  <= cfg_base;
            limit_r[cfg_proc] <= cfg_limit;
        end
    end

    ram_sp_1clk #(
        .DATA_W (DATA_W),
        .ADDR_W (PADDR_W)
    ) u_ram (
        .clk  (clka),
        .en   (ram_en_s),
        .we   (wr_r),
        .addr (paddr_r),
        .din  (wdata_r),
        .dout (ram_dout_s)
    );

    // The RAM output register is the read-data register; it is idle in RESP.
    assign rsp_rdata = rsp_from_ram_r ? ram_dout_s : {DATA_W{1'b0}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_fault = rsp_fault_r;
    assign req_ready = req_ready_r;

endmodule

// File: tb/tb_mmu_mem_responder.sv
// Randomised and directed bench for mmu_mem_responder against a
// base/limit + word-array reference model.
module tb_mmu_mem_responder;

    logic        clka = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_proc;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [15:0] rsp_rdata;
    logic        cfg_we;
    logic [2:0]  cfg_proc;
    logic [9:0]  cfg_base;
    logic [10:0] cfg_limit;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_base  [8];
    int          m_limit [8];
    logic [15:0] m_mem   [1024];
    bit          m_known [1024];

    mmu_mem_responder dut (
        .clka      (clka),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_proc  (req_proc),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .cfg_we    (cfg_we),
        .cfg_proc  (cfg_proc),
        .cfg_base  (cfg_base),
        .cfg_limit (cfg_limit)
    );

    always #5 clka = ~clka;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_base[i]  = 0;
            m_limit[i] = (i == 0) ? 1024 : 0;
        end
    endtask

    function automatic bit m_fault(input int p, input int a);
        return (a >= m_limit[p]) || (m_base[p] + a > 1023);
    endfunction

    task automatic cfg(input int p, input int b, input int l);
        @(negedge clka);
        cfg_we    = 1'b1;
        cfg_proc  = 3'(p);
        cfg_base  = 10'(b);
        cfg_limit = 11'(l);
        @(negedge clka);
        cfg_we    = 1'b0;
        m_base[p]  = b;
        m_limit[p] = l;
    endtask

    // One request/response; race=1 rewrites this process's window during XLATE.
    task automatic xact(input bit w, input int p, input int a, input logic [15:0] d,
                        input int hold, input bit race);
        bit          exp_f, chk_d;
        logic [15:0] exp_d;
        int          pa, lat, guard;
        exp_f = m_fault(p, a);
        pa    = (m_base[p] + a) % 1024;
        exp_d = 16'h0000;
        chk_d = 1'b1;
        if (!exp_f && !w) begin
            exp_d = m_mem[pa];
            chk_d = m_known[pa];
        end
        @(negedge clka);
        req_valid = 1'b1;
        req_write = w;
        req_proc  = 3'(p);
        req_addr  = 16'(a);
        req_wdata = d;
        rsp_ready = (hold > 0) ? 1'b0 : 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clka);
            guard++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clka);
        @(negedge clka);
        req_valid = 1'b0;
        if (race) begin
            cfg_we    = 1'b1;
            cfg_proc  = 3'(p);
            cfg_base  = 10'd0;
            cfg_limit = 11'd0;
            m_base[p]  = 0;
            m_limit[p] = 0;
        end
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clka);
            cfg_we = 1'b0;
            lat++;
        end
        cfg_we = 1'b0;
        check("rsp_latency", 32'(lat), exp_f ? 32'd1 : 32'd2);
        check("rsp_fault", 32'(rsp_fault), 32'(exp_f));
        if (chk_d) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        if (!exp_f && w) begin
            m_mem[pa]   = d;
            m_known[pa] = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clka);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_fault", 32'(rsp_fault), 32'(exp_f));
            if (chk_d) check("hold_rdata", 32'(rsp_rdata), 32'(exp_d));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clka);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("next_ready", 32'(req_ready), 32'd1);
        if (hold > 0) begin
            @(negedge clka);
            check("single_rsp", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int p, a, l;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_proc = 3'd0;
        req_addr = 16'd0; req_wdata = 16'd0; rsp_ready = 1'b1;
        cfg_we = 1'b0; cfg_proc = 3'd0; cfg_base = 10'd0; cfg_limit = 11'd0;
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clka);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0;

        xact(1'b1, 0, 5, 16'h1234, 0, 1'b0);
        xact(1'b0, 0, 5, 16'h0000, 0, 1'b0);
        cfg(2, 512, 16);
        xact(1'b1, 2, 3, 16'hBEEF, 0, 1'b0);
        xact(1'b0, 0, 515, 16'h0000, 0, 1'b0);
        xact(1'b0, 2, 16, 16'h0000, 0, 1'b0);
        xact(1'b1, 2, 15, 16'h0F0F, 0, 1'b0);
        xact(1'b0, 1, 0, 16'h0000, 0, 1'b0);
        cfg(3, 1000, 30);
        xact(1'b1, 3, 23, 16'hC0DE, 0, 1'b0);
        xact(1'b0, 3, 23, 16'h0000, 0, 1'b0);
        xact(1'b0, 0, 1023, 16'h0000, 0, 1'b0);
        xact(1'b1, 3, 24, 16'hDEAD, 0, 1'b0);
        xact(1'b0, 0, 16'h8005, 16'h0000, 0, 1'b0);
        xact(1'b0, 0, 5, 16'h0000, 5, 1'b0);
        xact(1'b0, 2, 16, 16'h0000, 3, 1'b0);
        xact(1'b0, 2, 3, 16'h0000, 0, 1'b1);
        xact(1'b0, 2, 3, 16'h0000, 0, 1'b0);

        // Reset while a write sits in ACCESS: the write must not land.
        xact(1'b1, 0, 7, 16'h5555, 0, 1'b0);
        @(negedge clka);
        req_valid = 1'b1; req_write = 1'b1; req_proc = 3'd0;
        req_addr = 16'd7; req_wdata = 16'hAAAA;
        @(posedge clka);
        @(negedge clka);
        req_valid = 1'b0;
        @(posedge clka);
        @(negedge clka);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clka);
        rst = 1'b0;
        model_reset();
        xact(1'b0, 0, 7, 16'h0000, 0, 1'b0);
        xact(1'b0, 3, 23, 16'h0000, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                p = $urandom_range(1, 7);
                cfg(p, $urandom_range(0, 1023), $urandom_range(0, 1024));
            end
            p = $urandom_range(0, 7);
            l = m_limit[p];
            if (l > 0 && $urandom_range(0, 3) != 0) a = $urandom_range(0, l - 1);
            else a = $urandom_range(0, 65535);
            xact(1'($urandom_range(0, 1)), p, a, 16'($urandom),
                 ($urandom_range(0, 5) == 0) ? 2 : 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
